// File: rtl/fmul_result_stage.sv
// Result stage behind the single-precision multiplier: in-order FIFO of {result, flags, tag}
// with sticky RISC-V fflags accumulated on commit. Optional bypass: FMUL_RESULT_BYPASS_EN.
module fmul_result_stage #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_result,
  input  logic [3:0]                 in_flags,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [3:0]                 out_flags,
  output logic [TAG_W-1:0]           out_tag,
  input  logic                       fflags_clr,
  output logic [4:0]                 fflags,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 32 + 4 + TAG_W;

  logic [EW-1:0] mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [4:0]    fflags_reg, fflags_next;
  logic [EW-1:0] head;
  logic          fifo_valid;
  logic          bypass;
  logic          do_push, do_pop, commit;

  assign head       = mem_reg[rd_ptr_reg];
  assign fifo_valid = (count_reg != '0);
  assign in_ready   = (count_reg != CW'(DEPTH));

`ifdef FMUL_RESULT_BYPASS_EN
  // An empty stage with a ready consumer hands the product straight through.
  assign bypass = (count_reg == '0) && in_valid && out_ready;

  always_comb begin
    out_valid                       = fifo_valid;
    {out_result, out_flags, out_tag} = head;
    if (bypass) begin
      out_valid  = 1'b1;
      out_result = in_result;
      out_flags  = in_flags;
      out_tag    = in_tag;
    end
  end
`else
  assign bypass = 1'b0;

  always_comb begin
    out_valid                        = fifo_valid;
    {out_result, out_flags, out_tag} = head;
  end
`endif

  assign do_push = in_valid && in_ready && !bypass;
  assign do_pop  = fifo_valid && out_ready;
  assign commit  = out_valid && out_ready;

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Clear is applied before the committed flags are ORed in, so a colliding commit survives.
  always_comb begin
    fflags_next = fflags_clr ? 5'b00000 : fflags_reg;
    if (commit)
      fflags_next = fflags_next | {out_flags[3], 1'b0, out_flags[2:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      fflags_reg <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_reg[i] <= '0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= {in_result, in_flags, in_tag};
        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
      end
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg  <= count_next;
      fflags_reg <= fflags_next;
    end
  end

  assign count  = count_reg;
  assign fflags = fflags_reg;

endmodule

// File: tb/tb_fmul_result_stage.sv
// Directed testbench for fmul_result_stage (DEPTH=2, TAG_W=5).
module tb_fmul_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_flags;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic [4:0]  out_tag;
  logic        fflags_clr;
  logic [4:0]  fflags;
  logic [1:0]  count;

  int total = 0;
  int bad   = 0;

  fmul_result_stage #(.DEPTH(2), .TAG_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_flags   (in_flags),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_tag    (out_tag),
    .fflags_clr (fflags_clr),
    .fflags     (fflags),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] r, input logic [3:0] f, input logic [4:0] t);
    in_valid  = 1'b1;
    in_result = r;
    in_flags  = f;
    in_tag    = t;
  endtask

  // Push one entry and let it commit (out_ready high).
  task automatic push_pop(input logic [31:0] r, input logic [3:0] f, input logic [4:0] t);
    drive(r, f, t);
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_flags = '0; in_tag = '0;
    out_ready = 1'b0; fflags_clr = 1'b0;
    #1;
    check("rst_count",  64'(count), 64'd0);
    check("rst_ovalid", 64'(out_valid), 64'd0);
    check("rst_fflags", 64'(fflags), 64'd0);
    check("rst_oresult", 64'(out_result), 64'd0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    tick();
    check("rst_iready", 64'(in_ready), 64'd1);

    // Single result
    out_ready = 1'b1;
    drive(32'h40C00000, 4'b0000, 5'd3);
    #1;
`ifdef FMUL_RESULT_BYPASS_EN
    check("single_byp_valid",  64'(out_valid), 64'd1);
    check("single_byp_result", 64'(out_result), 64'h40C00000);
    check("single_byp_tag",    64'(out_tag), 64'd3);
    tick();
    in_valid = 1'b0;
    #1;
    check("single_byp_count", 64'(count), 64'd0);
`else
    check("single_same_cycle_valid", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    #1;
    check("single_valid",  64'(out_valid), 64'd1);
    check("single_result", 64'(out_result), 64'h40C00000);
    check("single_tag",    64'(out_tag), 64'd3);
    check("single_count",  64'(count), 64'd1);
    tick();
    check("single_drain",  64'(count), 64'd0);
`endif
    check("single_fflags", 64'(fflags), 64'd0);

    // Fill and backpressure
    out_ready = 1'b0;
    drive(32'h00000001, 4'b0000, 5'd1);
    tick();
    drive(32'h00000002, 4'b0000, 5'd2);
    tick();
    check("full_iready", 64'(in_ready), 64'd0);
    check("full_count",  64'(count), 64'd2);
    drive(32'h00000007, 4'b0000, 5'd7);
    tick();
    check("held_count", 64'(count), 64'd2);
    check("held_head",  64'(out_tag), 64'd1);
    out_ready = 1'b1;
    tick();
    check("pop1_next_tag", 64'(out_tag), 64'd2);
    check("pop1_count",    64'(count), 64'd1);
    tick();
    in_valid = 1'b0;
    check("pop2_next_tag", 64'(out_tag), 64'd7);
    check("pop2_result",   64'(out_result), 64'h00000007);
    check("pop2_count",    64'(count), 64'd1);
    tick();
    check("drain_count",  64'(count), 64'd0);
    check("drain_ovalid", 64'(out_valid), 64'd0);

    // Flag accumulation
    push_pop(32'h7F800000, 4'b0101, 5'd4);
    check("acc1_fflags", 64'(fflags), 64'b00101);
    push_pop(32'h7FC00000, 4'b1000, 5'd5);
    check("acc2_fflags", 64'(fflags), 64'b10101);

    // Clear with no pop, then clear colliding with a commit
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    check("clr_only_fflags", 64'(fflags), 64'd0);
    push_pop(32'h7FC00000, 4'b1000, 5'd6);
    check("pre_collide_fflags", 64'(fflags), 64'b10000);
    out_ready = 1'b0;
    drive(32'h00800000, 4'b0011, 5'd8);
    tick();
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    check("collide_fflags", 64'(fflags), 64'b00011);

    // Stall stability
    out_ready = 1'b0;
    drive(32'h7FC00000, 4'b0001, 5'd9);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_result", i), 64'(out_result), 64'h7FC00000);
      check($sformatf("stall%0d_tag", i),    64'(out_tag), 64'd9);
      check($sformatf("stall%0d_flags", i),  64'(out_flags), 64'b0001);
      check($sformatf("stall%0d_fflags", i), 64'(fflags), 64'b00011);
      tick();
    end
    check("stall_valid", 64'(out_valid), 64'd1);

    // Pop the NaN entry while clearing: fflags becomes NX only
    out_ready  = 1'b1;
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    out_ready  = 1'b0;
    check("nx_only_fflags", 64'(fflags), 64'b00001);

    // Reset mid-stream
    drive(32'h3F800000, 4'b0000, 5'd10);
    tick();
    drive(32'h40000000, 4'b0000, 5'd11);
    tick();
    in_valid = 1'b0;
    check("prerst_count", 64'(count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_count",  64'(count), 64'd0);
    check("midrst_ovalid", 64'(out_valid), 64'd0);
    check("midrst_fflags", 64'(fflags), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("postrst_iready", 64'(in_ready), 64'd1);
    check("postrst_fflags", 64'(fflags), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
